// File: rtl/exc_ctrl.sv
// Exception responder beside the LEGv8 execute stage: takes bad-opcode, ERET
// and external IRQ events, keeps ELR/ESR/ERR, and redirects/flushes the pipeline.
module exc_ctrl #(
  parameter int             N            = 64,
  parameter logic [N-1:0]   VECTOR       = 64'h0000_0000_0000_00D8,
  parameter int             DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid_E,
  input  logic         NotAnInstr_E,
  input  logic         ERet_E,
  input  logic [N-1:0] pc_E,
  input  logic         ext_irq,
  output logic         irq_ack,
  input  logic [1:0]   mrs_sel,
  output logic [N-1:0] mrs_rdata,
  output logic         pc_redirect,
  output logic [N-1:0] redirect_pc,
  output logic         flush,
  output logic         in_handler
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN_IN, HANDLER, DRAIN_OUT} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [N-1:0]   elr_reg, elr_next;
  logic [N-1:0]   err_reg, err_next;
  logic [1:0]     esr_reg, esr_next;

  logic bad, eret, irq;

  // Events are suppressed while reset is asserted so no pulse leaks out.
  assign bad  = instr_valid_E & NotAnInstr_E & ~reset;
  assign eret = instr_valid_E & ERet_E & ~reset;
  assign irq  = ext_irq & (state_reg == RUN) & ~reset;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    elr_next    = elr_reg;
    err_next    = err_reg;
    esr_next    = esr_reg;
    irq_ack     = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    flush       = 1'b0;
    in_handler  = 1'b0;

    case (state_reg)
      RUN: begin
        if (bad || eret || irq) begin
          elr_next    = pc_E;
          if (bad) begin
            esr_next = 2'd1;
            err_next = pc_E + N'(4);
          end else if (eret) begin
            esr_next = 2'd3;
            err_next = pc_E + N'(4);
          end else begin
            // Interrupted instruction is re-executed on return.
            esr_next = 2'd2;
            err_next = pc_E;
            irq_ack  = 1'b1;
          end
          pc_redirect = 1'b1;
          redirect_pc = VECTOR;
          flush       = 1'b1;
          cnt_next    = CW'(DRAIN_CYCLES - 1);
          state_next  = DRAIN_IN;
        end
      end
      DRAIN_IN: begin
        flush = 1'b1;
        if (cnt_reg == '0) state_next = HANDLER;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (bad) begin
          esr_next    = 2'd1;
          elr_next    = pc_E;
          err_next    = pc_E + N'(4);
          pc_redirect = 1'b1;
          redirect_pc = VECTOR;
          flush       = 1'b1;
          cnt_next    = CW'(DRAIN_CYCLES - 1);
          state_next  = DRAIN_IN;
        end else if (eret) begin
          pc_redirect = 1'b1;
          redirect_pc = err_reg;
          flush       = 1'b1;
          cnt_next    = CW'(DRAIN_CYCLES - 1);
          state_next  = DRAIN_OUT;
        end
      end
      DRAIN_OUT: begin
        flush = 1'b1;
        if (cnt_reg == '0) state_next = RUN;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      elr_reg   <= '0;
      err_reg   <= '0;
      esr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      elr_reg   <= elr_next;
      err_reg   <= err_next;
      esr_reg   <= esr_next;
    end
  end

  always_comb begin
    case (mrs_sel)
      2'b00:   mrs_rdata = elr_reg;
      2'b01:   mrs_rdata = {{(N-2){1'b0}}, esr_reg};
      2'b10:   mrs_rdata = err_reg;
      default: mrs_rdata = '0;
    endcase
  end

endmodule
